field_ram: RTL and testbench



---
 rtl/field_ram_if.sv | 25 ++
 rtl/field_ram.sv | 118 +++++++++++
 tb/tb_field_ram.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/field_ram_if.sv
// field_ram_if: LCD read port, game read/write port and line-clear control of the playfield RAM.
interface field_ram_if;
  logic [8:0] i_block_addr;
  logic [3:0] o_block_data;
  logic [3:0] i_rd_x;
  logic [4:0] i_rd_y;
  logic [3:0] o_rd_data;
  logic       i_wr_en;
  logic [3:0] i_wr_x;
  logic [4:0] i_wr_y;
  logic [3:0] i_wr_data;
  logic       i_clear_req;
  logic       i_game_reset_pls;
  logic       o_busy;
  logic       o_line_remove_pls;
  logic       o_clear_done;
  modport slave (
    input  i_block_addr, i_rd_x, i_rd_y, i_wr_en, i_wr_x, i_wr_y, i_wr_data, i_clear_req, i_game_reset_pls,
    output o_block_data, o_rd_data, o_busy, o_line_remove_pls, o_clear_done
  );
  modport master (
    output i_block_addr, i_rd_x, i_rd_y, i_wr_en, i_wr_x, i_wr_y, i_wr_data, i_clear_req, i_game_reset_pls,
    input  o_block_data, o_rd_data, o_busy, o_line_remove_pls, o_clear_done
  );
endinterface

// File: rtl/field_ram.sv
// field_ram: Tetris playfield RAM with LCD read port, game access, field init and full-line removal.
module field_ram #(
  parameter int         FIELD_W   = 12,
  parameter int         FIELD_H   = 22,
  parameter logic [3:0] WALL_CODE = 4'd1
) (
  input logic        i_clk,
  input logic        i_res_n,
  field_ram_if.slave bus
);
  localparam int         DEPTH = FIELD_W * FIELD_H;
  localparam logic [3:0] W     = 4'(FIELD_W);
  localparam logic [4:0] H     = 5'(FIELD_H);
  localparam logic [3:0] XL    = 4'(FIELD_W - 2);
  localparam logic [2:0] IDLE  = 3'd0, INIT = 3'd1, CHK = 3'd2, SHIFT = 3'd3, DONE = 3'd4;
  logic [3:0] mem [DEPTH];
  logic [2:0] state;
  logic [4:0] r, sy, p_row;
  logic [3:0] sx, p_col, fsm_q, wdata;
  logic [8:0] b_raddr, waddr;
  logic       p_vld, p_last, full, idle, rd_ok, wr_ok, issue, row_full, we;
  function automatic logic [8:0] idx(input logic [4:0] y, input logic [3:0] x);
    return 9'(y) * 9'(FIELD_W) + 9'(x);
  endfunction
  assign idle     = state == IDLE;
  assign rd_ok    = idle && bus.i_rd_x < W && bus.i_rd_y < H;
  assign wr_ok    = idle && bus.i_wr_en && !bus.i_game_reset_pls && bus.i_wr_x < W && bus.i_wr_y < H;
  assign issue    = sx <= XL;
  assign row_full = full && fsm_q != 4'd0;
  // SHIFT reads the row above the destination; row 0 has no source and is filled with zeros
  assign b_raddr  = idle ? (rd_ok ? idx(bus.i_rd_y, bus.i_rd_x) : 9'd0)
                  : idx(state == SHIFT ? (sy == 5'd0 ? 5'd0 : sy - 5'd1) : r, sx);
  assign we       = state == INIT || (state == SHIFT && p_vld) || wr_ok;
  assign waddr    = state == INIT ? idx(sy, sx) : state == SHIFT ? idx(p_row, p_col) : idx(bus.i_wr_y, bus.i_wr_x);
  assign wdata    = state == INIT ? ((sx == 4'd0 || sx == W - 4'd1 || sy == H - 5'd1) ? WALL_CODE : 4'd0)
                  : state == SHIFT ? (p_row == 5'd0 ? 4'd0 : fsm_q) : bus.i_wr_data;
  assign bus.o_busy       = !(idle || state == DONE);
  assign bus.o_clear_done = state == DONE;
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    fsm_q <= mem[b_raddr];
  end
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      bus.o_block_data <= 4'd0;
      bus.o_rd_data    <= 4'd0;
    end else begin
      bus.o_block_data <= bus.i_block_addr < 9'(DEPTH) ? mem[bus.i_block_addr] : 4'd0;
      bus.o_rd_data    <= rd_ok ? mem[b_raddr] : WALL_CODE;
    end
  // Stage 1 issues one read per cycle at (sy/r, sx); stage 2 (p_*) consumes fsm_q one cycle later
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      state                 <= INIT;
      r                     <= 5'd0;
      sy                    <= 5'd0;
      sx                    <= 4'd0;
      p_row                 <= 5'd0;
      p_col                 <= 4'd0;
      p_vld                 <= 1'b0;
      p_last                <= 1'b0;
      full                  <= 1'b1;
      bus.o_line_remove_pls <= 1'b0;
    end else if (bus.i_game_reset_pls) begin
      state                 <= INIT;
      sy                    <= 5'd0;
      sx                    <= 4'd0;
      p_vld                 <= 1'b0;
      p_last                <= 1'b0;
      full                  <= 1'b1;
      bus.o_line_remove_pls <= 1'b0;
    end else begin
      bus.o_line_remove_pls <= 1'b0;
      p_vld                 <= (state == CHK || state == SHIFT) && issue;
      p_last                <= sx == XL && (state == CHK || (state == SHIFT && sy == 5'd0));
      p_row                 <= sy;
      p_col                 <= sx;
      case (state)
        INIT: begin
          sx <= sx == W - 4'd1 ? 4'd0 : sx + 4'd1;
          if (sx == W - 4'd1) sy <= sy + 5'd1;
          if (sx == W - 4'd1 && sy == H - 5'd1) state <= IDLE;
        end
        IDLE: if (bus.i_clear_req) begin
          state <= CHK;
          r     <= H - 5'd2;
          sx    <= 4'd1;
          full  <= 1'b1;
        end
        CHK: begin
          if (issue) sx <= sx + 4'd1;
          if (p_vld && fsm_q == 4'd0) full <= 1'b0;
          if (p_last) begin
            full <= 1'b1;
            sx   <= 4'd1;
            if (row_full) begin
              bus.o_line_remove_pls <= 1'b1;
              state                 <= SHIFT;
              sy                    <= r;
            end else if (r == 5'd0) state <= DONE;
            else r <= r - 5'd1;
          end
        end
        SHIFT: begin
          if (issue) begin
            sx <= (sx == XL && sy != 5'd0) ? 4'd1 : sx + 4'd1;
            if (sx == XL && sy != 5'd0) sy <= sy - 5'd1;
          end
          if (p_last) begin
            state <= CHK;
            sx    <= 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_field_ram.sv
// tb_field_ram: directed table-driven checks of field_ram init, access, line clear and abort.
module tb_field_ram;
  logic clk = 1'b0, res_n = 1'b0;
  field_ram_if bus();
  field_ram dut (.i_clk(clk), .i_res_n(res_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { bit lcd; int a; int x; int y; int exp; } vec_t;
  vec_t tbl [19];
  int n_chk = 0, n_fail = 0;
  int lines, dones, min_gap, last_ln, d, cnt, bad;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lcd(input int a, output int q);
    bus.i_block_addr = 9'(a);
    tick();
    q = int'(bus.o_block_data);
  endtask
  task automatic grd(input int x, input int y, output int q);
    bus.i_rd_x = 4'(x);
    bus.i_rd_y = 5'(y);
    tick();
    q = int'(bus.o_rd_data);
  endtask
  task automatic gwr(input int x, input int y, input int v, input bit clr);
    bus.i_wr_x      = 4'(x);
    bus.i_wr_y      = 5'(y);
    bus.i_wr_data   = 4'(v);
    bus.i_wr_en     = 1'b1;
    bus.i_clear_req = clr;
    tick();
    bus.i_wr_en     = 1'b0;
    bus.i_clear_req = 1'b0;
  endtask
  task automatic pulse_clear();
    bus.i_clear_req = 1'b1;
    tick();
    bus.i_clear_req = 1'b0;
  endtask
  task automatic run(input int n);
    lines = 0; dones = 0; min_gap = 1000000; last_ln = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.o_line_remove_pls) begin
        if (last_ln >= 0 && i - last_ln < min_gap) min_gap = i - last_ln;
        last_ln = i;
        lines++;
      end
      if (bus.o_clear_done) dones++;
    end
  endtask
  task automatic row_bad(input int y, input int skip_x, output int nb);
    int q;
    nb = 0;
    for (int x = 1; x <= 10; x++) begin
      grd(x, y, q);
      if (x != skip_x && q != 0) nb++;
    end
  endtask
  task automatic count_busy(output int c);
    c = 0;
    lines = 0; dones = 0;
    for (int i = 0; i < 2000 && bus.o_busy; i++) begin
      tick();
      c++;
      if (bus.o_line_remove_pls) lines++;
      if (bus.o_clear_done) dones++;
    end
  endtask
  initial begin
    tbl = '{'{1, 0, 0, 0, 1}, '{1, 11, 0, 0, 1}, '{1, 12, 0, 0, 1}, '{1, 13, 0, 0, 0},
            '{1, 130, 0, 0, 0}, '{1, 252, 0, 0, 1}, '{1, 258, 0, 0, 1}, '{1, 263, 0, 0, 1},
            '{1, 264, 0, 0, 0}, '{1, 240, 0, 0, 1}, '{1, 241, 0, 0, 0}, '{1, 251, 0, 0, 1},
            '{0, 0, 12, 0, 1}, '{0, 0, 13, 2, 1}, '{0, 0, 5, 3, 0}, '{0, 0, 0, 5, 1},
            '{0, 0, 10, 20, 0}, '{0, 0, 3, 21, 1}, '{0, 0, 4, 22, 1}};
    bus.i_block_addr = '0; bus.i_rd_x = '0; bus.i_rd_y = '0; bus.i_wr_en = 1'b0;
    bus.i_wr_x = '0; bus.i_wr_y = '0; bus.i_wr_data = '0; bus.i_clear_req = 1'b0;
    bus.i_game_reset_pls = 1'b0;
    #12;
    check("rst_busy", int'(bus.o_busy), 1);
    check("rst_block_data", int'(bus.o_block_data), 0);
    check("rst_rd_data", int'(bus.o_rd_data), 0);
    check("rst_pulses", int'({bus.o_line_remove_pls, bus.o_clear_done}), 0);
    @(posedge clk);
    #1;
    res_n = 1'b1;
    count_busy(cnt);
    check("init_busy_cycles", cnt, 264);
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].lcd) lcd(tbl[i].a, d);
      else grd(tbl[i].x, tbl[i].y, d);
      check($sformatf("vec%0d", i), d, tbl[i].exp);
    end
    gwr(5, 3, 4, 1'b0);
    lcd(41, d);
    check("lcd_after_write", d, 4);
    grd(5, 3, d);
    check("rd_after_write", d, 4);
    for (int x = 1; x <= 10; x++) gwr(x, 20, 2, 1'b0);
    gwr(4, 19, 3, 1'b0);
    pulse_clear();
    run(1500);
    check("clr1_lines", lines, 1);
    check("clr1_done", dones, 1);
    check("clr1_busy_end", int'(bus.o_busy), 0);
    grd(4, 20, d);
    check("clr1_cell_4_20", d, 3);
    grd(4, 19, d);
    check("clr1_cell_4_19", d, 0);
    row_bad(20, 4, bad);
    check("clr1_row20_nonzero", bad, 0);
    grd(0, 20, d);
    check("clr1_left_wall", d, 1);
    grd(11, 20, d);
    check("clr1_right_wall", d, 1);
    lcd(257, d);
    check("clr1_bottom_wall", d, 1);
    grd(5, 4, d);
    check("clr1_moved_5_4", d, 4);
    for (int y = 17; y <= 20; y++)
      for (int x = 1; x <= 10; x++) gwr(x, y, (x % 3) + 1, y == 20 && x == 10);
    run(3000);
    check("clr4_lines", lines, 4);
    check("clr4_gap_ge10", int'(min_gap >= 10), 1);
    check("clr4_done", dones, 1);
    cnt = 0;
    for (int y = 17; y <= 20; y++) begin
      row_bad(y, 0, bad);
      cnt += bad;
    end
    check("clr4_rows_nonzero", cnt, 0);
    grd(5, 8, d);
    check("clr4_moved_5_8", d, 4);
    for (int x = 1; x <= 10; x++) gwr(x, 20, 7, 1'b0);
    gwr(6, 2, 5, 1'b0);
    pulse_clear();
    cnt = 0;
    while (cnt < 200 && !bus.o_line_remove_pls) begin
      tick();
      cnt++;
    end
    check("abort_first_pulse_seen", int'(bus.o_line_remove_pls), 1);
    repeat (5) tick();
    bus.i_game_reset_pls = 1'b1;
    tick();
    bus.i_game_reset_pls = 1'b0;
    count_busy(cnt);
    check("abort_busy_cycles", cnt, 264);
    check("abort_pulses_during", lines + dones, 0);
    run(50);
    check("abort_pulses_after", lines + dones, 0);
    grd(6, 2, d);
    check("abort_reinit_6_2", d, 0);
    grd(5, 8, d);
    check("abort_reinit_5_8", d, 0);
    row_bad(20, 0, bad);
    check("abort_row20_nonzero", bad, 0);
    lcd(0, d);
    check("abort_wall_0", d, 1);
    gwr(3, 20, 6, 1'b0);
    pulse_clear();
    gwr(7, 10, 9, 1'b0);
    grd(3, 20, d);
    check("busy_rd_wall", d, 1);
    pulse_clear();
    run(600);
    check("busy_done_once", dones, 1);
    check("busy_no_lines", lines, 0);
    grd(7, 10, d);
    check("busy_write_dropped", d, 0);
    grd(3, 20, d);
    check("busy_cell_kept", d, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
